// File: rtl/inst_fetch.sv
// Instruction memory and fetch unit for the core front end.
//
// A handshaked loader fills the memory in LOAD mode. load_done switches to RUN, where
// instructions are fetched sequentially. Decode-stage jumps and execute-stage branches
// redirect the fetch with no bubble cycles. The branch source has the higher priority.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   load_data_i       program word to store
//   load_valid_i      load_data_i is valid this cycle
//   load_ready_o      loader can accept a word
//   load_done_i       end of program: LOAD -> RUN
//   loaded_words_o    number of words written since the last reset
//   restart_i         RUN only: return to pc 0 without reloading
//   stall_i           freeze pc and the fetch outputs
//   is_j_i, c_j_i     decode-stage jump request and target
//   br_taken_i        execute-stage branch redirect
//   br_target_i       execute-stage branch target
//   pc_o              address of the next sequential fetch
//   inst_bits_o       fetched instruction (registered)
//   inst_valid_o      inst_bits_o holds a real fetched instruction
module inst_fetch #(
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INST_WIDTH-1:0] load_data_i,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    input  logic                  load_done_i,
    output logic [ADDR_WIDTH:0]   loaded_words_o,
    input  logic                  restart_i,
    input  logic                  stall_i,
    input  logic                  is_j_i,
    input  logic [ADDR_WIDTH-1:0] c_j_i,
    input  logic                  br_taken_i,
    input  logic [ADDR_WIDTH-1:0] br_target_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [INST_WIDTH-1:0] inst_bits_o,
    output logic                  inst_valid_o
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    typedef enum logic {
        StLoad,
        StRun
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   load_cnt_q, load_cnt_d;
    logic [ADDR_WIDTH:0]     loaded_q, loaded_d;
    logic [INST_WIDTH-1:0]   bits_q, bits_d;
    logic                    valid_q, valid_d;

    logic [INST_WIDTH-1:0]   mem_q [Depth];
    logic [ADDR_WIDTH-1:0]   redir_addr;
    logic [INST_WIDTH-1:0]   seq_word;
    logic [INST_WIDTH-1:0]   redir_word;
    logic                    load_fire;

    // The count saturates at Depth, so its MSB alone flags a full memory.
    assign load_ready_o = (state_q == StLoad) && !loaded_q[ADDR_WIDTH];
    assign load_fire    = load_valid_i && load_ready_o;

    // Branch target wins the shared redirect read port over the jump target.
    assign redir_addr = br_taken_i ? br_target_i : c_j_i;
    assign seq_word   = mem_q[pc_q];
    assign redir_word = mem_q[redir_addr];

    // No reset on the array: contents survive rst_n so a program can be rerun. The rst_n
    // qualifier drops a write that would land on an edge while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && load_fire) begin
            mem_q[load_cnt_q] <= load_data_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        load_cnt_d = load_cnt_q;
        loaded_d   = loaded_q;
        bits_d     = bits_q;
        valid_d    = valid_q;
        unique case (state_q)
            StLoad: begin
                if (load_fire) begin
                    load_cnt_d = load_cnt_q + ADDR_WIDTH'(1);
                    loaded_d   = loaded_q + (ADDR_WIDTH + 1)'(1);
                end
                if (load_done_i) begin
                    state_d = StRun;
                    pc_d    = '0;
                    valid_d = 1'b0;
                end
            end
            StRun: begin
                if (restart_i) begin
                    pc_d    = '0;
                    bits_d  = '0;
                    valid_d = 1'b0;
                end else if (br_taken_i) begin
                    bits_d  = redir_word;
                    pc_d    = br_target_i + ADDR_WIDTH'(1);
                    valid_d = 1'b1;
                end else if (stall_i) begin
                    // hold everything
                end else if (is_j_i) begin
                    bits_d  = redir_word;
                    pc_d    = c_j_i + ADDR_WIDTH'(1);
                    valid_d = 1'b1;
                end else begin
                    bits_d  = seq_word;
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    valid_d = 1'b1;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StLoad;
            pc_q       <= '0;
            load_cnt_q <= '0;
            loaded_q   <= '0;
            bits_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            load_cnt_q <= load_cnt_d;
            loaded_q   <= loaded_d;
            bits_q     <= bits_d;
            valid_q    <= valid_d;
        end
    end

    assign pc_o           = pc_q;
    assign loaded_words_o = loaded_q;
    assign inst_bits_o    = bits_q;
    assign inst_valid_o   = valid_q;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Parametrised instruction memory and fetch unit for the core front end. It supersedes the fixed-size fetch block and adds:
- a handshaked program loader with its own address counter and full detection;
- an explicit LOAD/RUN mode FSM;
- a fetch-valid flag;
- a second, higher-priority redirect source for taken branches from the execute stage.

Decode-stage jumps keep zero-bubble behaviour.

## Interface
- `INST_WIDTH`, 32, instruction word width.
- `ADDR_WIDTH`, 14, memory address width; depth = 2**ADDR_WIDTH words, distributed RAM.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `load_data`  in  INST_WIDTH  program word to store.
- `load_valid`  in  1  `load_data` is valid this cycle.
- `load_ready`  out  1  loader can accept a word.
- `load_done`  in  1  end of program; switches LOAD→RUN.
- `loaded_words`  out  ADDR_WIDTH+1  number of words written since the last reset.
- `restart`  in  1  in RUN: synchronous return to pc 0 without reloading.
- `stall`  in  1  freeze pc and the fetch outputs.
- `is_j`, `c_j`  in  1, ADDR_WIDTH  decode-stage jump request and target.
- `br_taken`, `br_target`  in  1, ADDR_WIDTH  execute-stage branch redirect and target.
- `pc`  out  ADDR_WIDTH  address of the next sequential fetch.
- `inst_bits`  out  INST_WIDTH  fetched instruction, registered.
- `inst_valid`  out  1  `inst_bits` holds a real fetched instruction.

## Operation
**Reset.** While `rst_n`=0:
- state is LOAD;
- `pc` and the load counter are 0;
- `loaded_words`, `inst_bits` and `inst_valid` are 0;
- `load_ready` is 1;
- memory contents are not cleared.

**LOAD state.**
- `load_ready` = 1 while `loaded_words` < depth.
- A word is accepted when `load_valid` && `load_ready`. It is written to `mem[load counter]`; the counter and `loaded_words` then increment.
- When `loaded_words` = depth, `load_ready` = 0. Further `load_valid` beats are dropped: no write, no count.
- `load_done` moves the FSM to RUN at the next edge.
  - If `load_done` and an accepted beat coincide, the word is written first.
  - On entry to RUN, `pc` = 0 and `inst_valid` = 0.
- In LOAD, `stall`, `is_j`, `br_taken` and `restart` are ignored, and `inst_valid` stays 0.

**RUN state.**
- `load_ready` = 0 and `load_valid` is ignored.
- Each edge, evaluated in this priority order:
  1. `restart`: `pc` ← 0, `inst_valid` ← 0, `inst_bits` ← 0.
  2. `br_taken`: `inst_bits` ← `mem[br_target]`, `pc` ← `br_target`+1, `inst_valid` ← 1.
     - Takes effect even when `stall`=1.
     - Squashes any simultaneous `is_j`.
  3. `stall`: `pc`, `inst_bits` and `inst_valid` all hold.
  4. `is_j`: `inst_bits` ← `mem[c_j]`, `pc` ← `c_j`+1, `inst_valid` ← 1.
  5. Otherwise: `inst_bits` ← `mem[pc]`, `pc` ← `pc`+1, `inst_valid` ← 1.
- Address arithmetic is modulo depth. `pc` wraps from depth−1 to 0, and a target of depth−1 yields `pc` 0.
- Fetches beyond `loaded_words` return whatever memory contains; this is not flagged.
- Leaving RUN requires `rst_n`.

**Memory.** Two asynchronous read ports, addressed by `pc` and by the selected redirect target, feed the registered `inst_bits`. There is one synchronous write port, driven by the load counter.

## Timing
- Fetch latency: 1 cycle from address (`pc`, `c_j` or `br_target`) to `inst_bits`.
- Redirects (jump or branch) cost no bubble cycles.
- First valid instruction: the edge after `load_done` enters RUN; the next edge gives `inst_bits` = `mem[0]`, `inst_valid` = 1, `pc` = 1.
- `restart` inserts exactly one invalid cycle; `mem[0]` follows on the next edge.
- `load_ready` and `loaded_words` update on the edge that accepts a word.
- `load_ready` is derived combinationally from state and count.
- Asynchronous reset mid-load or mid-run:
  - all outputs go to their reset values immediately;
  - an in-flight write on that edge is not performed;
  - after reset, a program must be reloaded, or `load_done` asserted to rerun existing contents.

## Test plan
- **Load then run.** Load 4 words A,B,C,D, then `load_done`.
  - Expect `loaded_words` = 4.
  - Then `inst_bits` A,B,C,D on successive cycles with `inst_valid` = 1 and `pc` 1..4.
- **Full and coincident done.** With `ADDR_WIDTH`=3, send 9 beats.
  - Expect `load_ready` = 0 after 8 and `loaded_words` = 8.
  - `mem[0]` must not be overwritten by the 9th beat.
  - `load_done` coincident with the 8th beat still writes it.
- **Jump and branch collision.** Assert `is_j` with `c_j`=5 and `br_taken` with `br_target`=2 in the same cycle.
  - Expect `inst_bits` = `mem[2]` and `pc` = 3.
  - Next cycle, a `is_j` with `c_j`=5 alone gives `mem[5]` and `pc` = 6.
- **Stall.** Hold `stall` for 3 cycles mid-stream.
  - `pc`, `inst_bits` and `inst_valid` must be unchanged.
  - `br_taken` during the stall must redirect immediately.
- **Wrap and restart.** With `ADDR_WIDTH`=3, run past pc 7.
  - Expect `pc` to go 0 after `mem[7]`.
  - `restart` gives `inst_valid` = 0 for one cycle, then `mem[0]`.
- **Asynchronous reset mid-run.** Assert `rst_n`=0 between clock edges.
  - `inst_valid`, `pc` and `loaded_words` must drop to 0 immediately, and the state must be LOAD.
  - After `load_done` with no new load, fetch must return the previous program.
